// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if -- byte handshake between a producer and the UART transmitter.
//
// Signals:
//   tx_data  [7:0]  byte to transmit, sampled only when tx_valid & tx_ready
//   tx_valid        producer has a byte; held until accepted
//   tx_ready        transmitter can accept a byte (idle)
//
// Modports:
//   master  producer side (drives tx_data / tx_valid)
//   slave   transmitter side (drives tx_ready)
// ---------------------------------------------------------------------------
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8-bit UART transmitter, LSB first, one stop bit.
//
// Frame: start(0), d0..d7, [even parity], stop(1); each bit lasts
// CLKS_PER_BIT clock cycles. The default build is 8N1 (10 bit periods).
// Defining the macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit (11 bit periods).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, 2..65535 (5208 = 50 MHz/9600)
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst     asynchronous active-low reset
//   tx_if   byte handshake (slave modport): tx_data, tx_valid, tx_ready
//   tx      serial output, idle high, driven straight from a flop
//   busy    high from the cycle after acceptance through the last stop cycle
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_if.slave      tx_if,
    output logic          tx,
    output logic          busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // baud counter, 0..CLKS_PER_BIT-1
    logic [2:0]       idx_q, idx_d;      // data bit index, 0..7
    logic [7:0]       shift_q, shift_d;  // bit 0 is the data bit on the line
    logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bit_done;
    logic accept;
    logic ready;

    assign bit_done = (cnt_q == CNT_MAX);
    assign accept   = (state_q == IDLE) && tx_if.tx_valid;

    // -----------------------------------------------------------------------
    // State register (and datapath registers)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge, regardless of statement order.
    // NOTE: the shift register is reset as well; it is a handful of flops,
    // not a memory, and a defined 0x00 after reset keeps the line predictable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept)   state_d = START;
            START: if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            STOP:  if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == IDLE) begin
            // Counters sit at zero while idle, so a frame always starts from
            // a clean bit boundary on acceptance.
            cnt_d = '0;
            idx_d = '0;
            if (accept) begin
                shift_d  = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^tx_if.tx_data;
`endif
            end
        end else if (bit_done) begin
            cnt_d = '0;
            if (state_q == DATA) begin
                idx_d   = idx_q + 3'd1;
                shift_d = {1'b0, shift_q[7:1]};
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The line level is chosen from the state being entered so the
        // registered tx changes exactly at the bit boundary.
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:   tx_d = 1'b1;
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            STOP:   tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Handshake status depends on state only, never on tx_valid.
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q != IDLE);
    end

    assign tx_if.tx_ready = ready;
    assign tx             = tx_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx with CLKS_PER_BIT = 4.
// Frame length follows UART_TX_PARITY_EN (10 or 11 bit periods).
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;     // hand-computed even parity of data
        logic       toggle;  // disturb tx_data/tx_valid mid-frame
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for bit period k of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input logic par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && NBITS == 11) return par;
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " tx"},    tx,           1);
        check({tag, " ready"}, bus.tx_ready, 1);
        check({tag, " busy"},  busy,         0);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic accept(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks every cycle of one frame; returns at the first negedge after it.
    task automatic check_frame(input logic [7:0] d, input logic par, input logic toggle,
                               input string tag);
        for (int j = 0; j < FRAME_CYC; j++) begin
            check($sformatf("%s tx c%0d", tag, j),    tx,           exp_bit(d, par, j / CPB));
            check($sformatf("%s busy c%0d", tag, j),  busy,         1);
            check($sformatf("%s ready c%0d", tag, j), bus.tx_ready, 0);
            if (toggle && j == 13) begin
                bus.tx_data  = ~d;
                bus.tx_valid = 1'b1;
            end
            if (toggle && j == 21) bus.tx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lows;

        vecs[0] = '{8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'hC3, 1'b0, 1'b0};
        vecs[8] = '{8'hE5, 1'b1, 1'b1};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst          = 1'b1;
        #2 rst = 1'b0;
        #1 check_idle("reset async");
        repeat (3) @(negedge clk);
        check_idle("reset held");

        // Release and accept on the very first edge after reset.
        rst = 1'b1;
        for (int v = 0; v < 9; v++) begin
            accept(vecs[v].data);
            bus.tx_valid = 1'b0;
            check_frame(vecs[v].data, vecs[v].par, vecs[v].toggle, $sformatf("vec%0d", v));
            check_idle($sformatf("vec%0d end", v));
        end

        // A tx_valid pulse that never spans a rising edge must be ignored.
        #2 bus.tx_valid = 1'b1;
        #2 bus.tx_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle("glitch valid");
        end

        // Back-to-back: valid held high, exactly one idle cycle between frames.
        accept(8'hA3);
        bus.tx_data = 8'h3C;
        check_frame(8'hA3, 1'b0, 1'b0, "b2b first");
        check_idle("b2b gap");
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_frame(8'h3C, 1'b0, 1'b0, "b2b second");
        check_idle("b2b end");

        // Reset during data bit 3 of 0xFF (cycles 16..19 of the frame).
        accept(8'hFF);
        bus.tx_valid = 1'b0;
        for (int j = 0; j < 17; j++) begin
            check($sformatf("abort tx c%0d", j), tx, exp_bit(8'hFF, 1'b0, j / CPB));
            @(negedge clk);
        end
        rst = 1'b0;
        #1 check_idle("abort async");
        @(negedge clk);
        rst = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("abort no retransmit lows", lows, 0);
        check_idle("abort end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx
